char_lcd_ctrl: RTL and testbench

CHAR_LCD_CTRL -- requirements
Module: char_lcd_ctrl

---
 rtl/char_lcd_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_char_lcd_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_lcd_ctrl.sv
// HD44780 character LCD controller: power-up init, then continuous redraw of a ROWS x COLS buffer.
// Optional macro LCD_MODE_BANNER_EN replaces row 0 with a fixed banner chosen by mode.
module char_lcd_ctrl #(
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int CLK_DIV  = 4,
  parameter int CLR_WAIT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       wr_en,
  input  logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       frame_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);
  // state      | meaning
  // INIT       | init command (0x38, 0x0C, 0x06, 0x01) on the bus, or about to launch the first
  // CLR_WAIT   | bus idle with E low while the display clear completes
  // SET_ADDR   | DDRAM address command for the current row on the bus
  // WRITE_CHAR | character of the current row on the bus, more columns follow
  // NEXT       | last character of the row on the bus; row advance follows
  localparam int DEPTH = ROWS * COLS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;
  localparam logic [DW-1:0] DIV_LD   = DW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LD  = WW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic          ROW_LAST = 1'(ROWS - 1);

  typedef enum logic [2:0] {S_INIT, S_CLR_WAIT, S_SET_ADDR, S_WRITE_CHAR, S_NEXT} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t          state;
  phase_t          phase;
  logic [DW-1:0]   div_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [1:0]      init_idx;
  logic            row;
  logic [CW-1:0]   col;
  logic [7:0]      mem [DEPTH];
  logic [CW-1:0]   nxt_col;
  logic [AW-1:0]   rd_idx;
  logic [7:0]      nxt_char;

  assign lcd_rw = 1'b0;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

`ifdef LCD_MODE_BANNER_EN
  function automatic logic [7:0] banner_char(input logic [1:0] m, input logic [CW-1:0] c);
    logic [71:0] txt;
    case (m)
      2'd0:    txt = {"WATCH", "    "};
      2'd1:    txt = {"ALARM", "    "};
      2'd2:    txt = "STOPWATCH";
      default: txt = {"----", "     "};
    endcase
    if (int'(c) < 9) banner_char = txt[8*(8-int'(c)) +: 8];
    else             banner_char = 8'h20;
  endfunction
`else
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Character for the transaction launched at the end of the current one
  always_comb begin
    nxt_col  = (state == S_WRITE_CHAR) ? col + CW'(1) : '0;
    rd_idx   = AW'(int'(row) * COLS + int'(nxt_col));
    nxt_char = mem[rd_idx];
`ifdef LCD_MODE_BANNER_EN
    if (row == 1'b0) nxt_char = banner_char(mode, nxt_col);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      phase      <= PH_IDLE;
      div_cnt    <= '0;
      wait_cnt   <= '0;
      init_idx   <= '0;
      row        <= 1'b0;
      col        <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (phase == PH_IDLE) begin
        if (state == S_CLR_WAIT) begin
          if (wait_cnt == '0) begin
            init_done <= 1'b1;
            state     <= S_SET_ADDR;
            row       <= 1'b0;
            phase     <= PH_SETUP;
            div_cnt   <= DIV_LD;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h80;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end else begin
          state    <= S_INIT;
          phase    <= PH_SETUP;
          div_cnt  <= DIV_LD;
          lcd_rs   <= 1'b0;
          lcd_data <= init_cmd(init_idx);
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - DW'(1);
      end else begin
        div_cnt <= DIV_LD;
        case (phase)
          PH_SETUP: begin
            phase <= PH_PULSE;
            lcd_e <= 1'b1;
          end
          PH_PULSE: begin
            phase <= PH_HOLD;
            lcd_e <= 1'b0;
          end
          default: begin
            // End of HOLD: launch the next transaction back to back
            phase <= PH_SETUP;
            case (state)
              S_INIT: begin
                if (init_idx == 2'd3) begin
                  if (CLR_WAIT == 0) begin
                    init_done <= 1'b1;
                    state     <= S_SET_ADDR;
                    row       <= 1'b0;
                    lcd_rs    <= 1'b0;
                    lcd_data  <= 8'h80;
                  end else begin
                    state    <= S_CLR_WAIT;
                    wait_cnt <= WAIT_LD;
                    phase    <= PH_IDLE;
                  end
                end else begin
                  init_idx <= init_idx + 2'd1;
                  lcd_rs   <= 1'b0;
                  lcd_data <= init_cmd(init_idx + 2'd1);
                end
              end
              S_SET_ADDR: begin
                col      <= '0;
                lcd_rs   <= 1'b1;
                lcd_data <= nxt_char;
                state    <= (COLS == 1) ? S_NEXT : S_WRITE_CHAR;
              end
              S_WRITE_CHAR: begin
                col      <= nxt_col;
                lcd_rs   <= 1'b1;
                lcd_data <= nxt_char;
                state    <= (nxt_col == COL_LAST) ? S_NEXT : S_WRITE_CHAR;
              end
              S_NEXT: begin
                state  <= S_SET_ADDR;
                lcd_rs <= 1'b0;
                if (row == ROW_LAST) begin
                  row        <= 1'b0;
                  frame_done <= 1'b1;
                  lcd_data   <= 8'h80;
                end else begin
                  row      <= row + 1'b1;
                  lcd_data <= 8'hC0;
                end
              end
              default: begin
                state <= S_INIT;
                phase <= PH_IDLE;
              end
            endcase
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_char_lcd_ctrl.sv
// Directed bench for char_lcd_ctrl: init sequence, refresh content and timing, range check, reset.
`timescale 1ns/1ps
module tb_char_lcd_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd2;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       init_done, frame_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic       wr2_en = 1'b0;
  logic [4:0] wr2_addr = '0;
  logic [7:0] wr2_data = '0;
  logic       init2_done, frame2_done, lcd2_e, lcd2_rs, lcd2_rw;
  logic [7:0] lcd2_data;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       initd;
    int         cyc;
  } txn_t;

  txn_t q[$];
  txn_t q2[$];
  int   fd_rise[$];
  int   id_rise[$];
  int   fd_hi = 0;
  logic e_q = 1'b0, e2_q = 1'b0, fd_q = 1'b0, id_q = 1'b0;
  logic [7:0] row0_exp [16];
  logic [7:0] exp2 [20];

  char_lcd_ctrl #(.COLS(16), .ROWS(2), .CLK_DIV(2), .CLR_WAIT(10)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done), .frame_done(frame_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  // 20-entry buffer so that 5-bit addresses 20..31 are out of range
  char_lcd_ctrl #(.COLS(10), .ROWS(2), .CLK_DIV(1), .CLR_WAIT(3)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .wr_en(wr2_en), .wr_addr(wr2_addr), .wr_data(wr2_data),
    .init_done(init2_done), .frame_done(frame2_done), .lcd_e(lcd2_e), .lcd_rs(lcd2_rs),
    .lcd_rw(lcd2_rw), .lcd_data(lcd2_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lcd_e && !e_q) q.push_back(txn_t'{lcd_rs, lcd_data, init_done, cyc});
    if (lcd2_e && !e2_q) q2.push_back(txn_t'{lcd2_rs, lcd2_data, init2_done, cyc});
    if (frame_done) begin
      fd_hi <= fd_hi + 1;
      if (!fd_q) fd_rise.push_back(cyc);
    end
    if (init_done && !id_q) id_rise.push_back(cyc);
    e_q  <= lcd_e;
    e2_q <= lcd2_e;
    fd_q <= frame_done;
    id_q <= init_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input bit second, input int n, input int budget, input string tag);
    int k = 0;
    while (((second ? q2.size() : q.size()) < n) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(tag, 32'((second ? q2.size() : q.size()) >= n), 32'd1);
  endtask

  initial begin
    logic [127:0] s;
    logic [79:0]  s2;
    logic [4:0]   a1 [6];
    logic [7:0]   d1 [6];
    logic [4:0]   a2 [6];
    logic [7:0]   d2 [6];
    logic [7:0]   ic [4];
    logic [7:0]   exp_r0;
    int rel, base, j, k, r, c;

    a1 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd16};
    d1 = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21};
    a2 = '{5'd20, 5'd31, 5'd19, 5'd0, 5'd25, 5'd10};
    d2 = '{8'h5A, 8'h5A, 8'h23, 8'h41, 8'h5A, 8'h42};
    ic = '{8'h38, 8'h0C, 8'h06, 8'h01};
`ifdef LCD_MODE_BANNER_EN
    s = {"STOPWATCH", "       "};
`else
    s = {"HELLO", "           "};
`endif
    for (int i = 0; i < 16; i++) row0_exp[i] = s[8*(15-i) +: 8];
    for (int i = 0; i < 20; i++) exp2[i] = 8'h20;
    exp2[0]  = 8'h41;
    exp2[10] = 8'h42;
    exp2[19] = 8'h23;
`ifdef LCD_MODE_BANNER_EN
    s2 = {"STOPWATCH", " "};
    for (int i = 0; i < 10; i++) exp2[i] = s2[8*(9-i) +: 8];
    exp_r0 = row0_exp[0];
`else
    exp_r0 = 8'h20;
`endif

    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({lcd_e, lcd_rs, lcd_rw, init_done, frame_done, lcd_data}), 32'd0);
    check("rst_outputs2", 32'({lcd2_e, lcd2_rs, lcd2_rw, init2_done, frame2_done, lcd2_data}), 32'd0);

    // Release and load both buffers while init is still running
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;  wr_addr = a1[i];  wr_data = d1[i];
      wr2_en = 1'b1; wr2_addr = a2[i]; wr2_data = d2[i];
      @(negedge clk);
      if (i == 0) check("first_cmd", 32'({lcd_e, lcd_rs, lcd_data}), 32'h038);
    end
    wr_en = 1'b0;
    wr2_en = 1'b0;
    check("rw_low", 32'(lcd_rw), 32'd0);

    wait_log(1'b0, 39, 600, "pass1_log");
    for (int i = 0; i < 4; i++)
      check($sformatf("init_cmd%0d", i), 32'({q[i].rs, q[i].data}), 32'(ic[i]));
    for (int i = 0; i < 3; i++)
      check($sformatf("init_gap%0d", i), 32'(q[i+1].cyc - q[i].cyc), 32'd6);
    check("first_e_latency", 32'(q[0].cyc - rel), 32'd3);
    check("clr_gap", 32'(q[4].cyc - q[3].cyc), 32'd16);
    check("init_done_before", 32'(q[3].initd), 32'd0);
    check("init_done_after", 32'(q[4].initd), 32'd1);
    check("addr_row0", 32'({q[4].rs, q[4].data}), 32'h080);
    check("init_done_rise", 32'(id_rise[0] - rel), 32'd35);
    for (int i = 0; i < 16; i++)
      check($sformatf("row0_col%0d", i), 32'({q[5+i].rs, q[5+i].data}), 32'({1'b1, row0_exp[i]}));
    check("addr_row1", 32'({q[21].rs, q[21].data}), 32'h0C0);
    for (int i = 0; i < 16; i++)
      check($sformatf("row1_col%0d", i), 32'({q[22+i].rs, q[22+i].data}),
            32'({1'b1, (i == 0) ? 8'h21 : 8'h20}));
    check("addr_wrap", 32'({q[38].rs, q[38].data}), 32'h080);
    for (int i = 4; i < 38; i++)
      check($sformatf("txn_gap%0d", i), 32'(q[i+1].cyc - q[i].cyc), 32'd6);

    k = 0;
    while (fd_rise.size() < 3 && k < 800) begin
      @(posedge clk);
      k++;
    end
    check("frame_count", 32'(fd_rise.size() >= 3), 32'd1);
    check("frame_align", 32'(fd_rise[0]), 32'(q[38].cyc - 2));
    check("frame_period1", 32'(fd_rise[1] - fd_rise[0]), 32'd204);
    check("frame_period2", 32'(fd_rise[2] - fd_rise[1]), 32'd204);
    check("frame_width", 32'(fd_hi), 32'(fd_rise.size()));

    // Second instance: out-of-range writes must not land anywhere
    wait_log(1'b1, 27, 200, "dut2_log");
    check("dut2_addr0", 32'({q2[4].rs, q2[4].data}), 32'h080);
    check("dut2_addr1", 32'({q2[15].rs, q2[15].data}), 32'h0C0);
    check("dut2_gap", 32'(q2[5].cyc - q2[4].cyc), 32'd3);
    for (int i = 0; i < 20; i++) begin
      r = i / 10;
      c = i % 10;
      check($sformatf("dut2_char%0d", i), 32'({q2[5 + r*11 + c].rs, q2[5 + r*11 + c].data}),
            32'({1'b1, exp2[i]}));
    end

    // Reset during an E pulse
    k = 0;
    while (!lcd_e && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("found_pulse", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_e_drop", 32'(lcd_e), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    base = q.size();
    @(negedge clk);
    check("restart_cmd", 32'({lcd_e, lcd_rs, lcd_data}), 32'h038);
    wait_log(1'b0, base + 23, 400, "restart_log");
    check("restart_first", 32'({q[base].rs, q[base].data}), 32'h038);
    check("restart_init_low", 32'(q[base+3].initd), 32'd0);
    check("restart_addr", 32'({q[base+4].rs, q[base+4].data, q[base+4].initd}), 32'h101);
    check("restart_latency", 32'(q[base+4].cyc - rel), 32'd37);
    check("restart_row0", 32'({q[base+5].rs, q[base+5].data}), 32'({1'b1, exp_r0}));
    check("restart_row1", 32'({q[base+22].rs, q[base+22].data}), 32'h120);
    check("init_rise_count", 32'(id_rise.size()), 32'd2);
    check("init_rise_time", 32'(id_rise[1] - rel), 32'd35);

`ifdef LCD_MODE_BANNER_EN
    // Switch mode between columns 3 and 4 of row 0
    base = q.size();
    j = -1;
    k = 0;
    while (j < 0 && k < 400) begin
      @(posedge clk);
      k++;
      for (int i = base; i < q.size(); i++)
        if (j < 0 && q[i].rs == 1'b0 && q[i].data == 8'h80) j = i;
    end
    check("banner_row0_found", 32'(j >= 0), 32'd1);
    wait_log(1'b0, j + 5, 100, "banner_col3_log");
    @(negedge clk);
    mode = 2'd0;
    wait_log(1'b0, j + 6, 100, "banner_col4_log");
    check("banner_col3", 32'(q[j+4].data), 32'h50);
    check("banner_switch", 32'(q[j+5].data), 32'h48);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
